// File: rtl/rcv_seq.sv
// Receive sequencer: steers assembled SPI words into the receive FIFO
// and drives the external size counter for write and burst commands.
module rcv_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_vld,
  input  logic        cmd_wr,
  input  logic        cs_rise,
  input  logic        word_vld,
  input  logic [31:0] word_data,
  input  logic        fifo_full,
  input  logic        rcv_last,
  input  logic        rcv_done,
  input  logic [15:0] rcv_size,
  output logic        rcv_wr_d,
  output logic        rcv_bc_d,
  output logic        rcv_clr,
  output logic        rcv_nxt0,
  output logic        rcv_nxt1,
  output logic        rcv_nxtk,
  output logic        fifo_wr,
  output logic [31:0] fifo_wdata,
  output logic [3:0]  fifo_be,
  output logic        rcv_busy,
  output logic        rcv_cmplt,
  output logic        rcv_ovf
);

  typedef enum logic [2:0] {
    IDLE, LOAD, CHK, RECV, DONE
  } state_t;

  state_t state_q, state_d;
  logic   cmd_wr_q, cmd_wr_d;
  logic   first_q, first_d;
  logic   ovf_q, ovf_d;
  logic   abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cmd_wr_q <= 1'b0;
      first_q  <= 1'b1;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_wr_q <= cmd_wr_d;
      first_q  <= first_d;
      ovf_q    <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cmd_wr_d  = cmd_wr_q;
    first_d   = first_q;
    ovf_d     = ovf_q;
    rcv_wr_d  = 1'b0;
    rcv_bc_d  = 1'b0;
    rcv_clr   = 1'b0;
    rcv_nxt0  = 1'b0;
    rcv_nxt1  = 1'b0;
    rcv_nxtk  = 1'b0;
    fifo_wr   = 1'b0;
    rcv_cmplt = 1'b0;
    rcv_busy  = (state_q != IDLE);
    abort     = cs_rise && (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (cmd_vld) begin
          state_d  = LOAD;
          cmd_wr_d = cmd_wr;
          ovf_d    = 1'b0;
          first_d  = 1'b1;
        end
      end
      LOAD: begin
        if (!abort) begin
          rcv_wr_d = cmd_wr_q;
          rcv_bc_d = !cmd_wr_q;
          state_d  = CHK;
        end
      end
      CHK: begin
        if (!abort) begin
          state_d = rcv_done ? DONE : RECV;
        end
      end
      RECV: begin
        if (!abort && word_vld) begin
          first_d = 1'b0;
          // Overflowed words still advance the count.
          if (fifo_full) begin
            rcv_nxtk = 1'b1;
            ovf_d    = 1'b1;
          end else begin
            fifo_wr  = 1'b1;
            rcv_nxt0 = first_q;
            rcv_nxt1 = !first_q;
          end
          if (rcv_last) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        rcv_clr   = 1'b1;
        rcv_cmplt = !cs_rise;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      rcv_clr = 1'b1;
      state_d = IDLE;
    end
  end

  always_comb begin
    fifo_be    = 4'b0000;
    fifo_wdata = 32'd0;
    if (fifo_wr) begin
      fifo_wdata = word_data;
      fifo_be    = 4'b1111;
      if (rcv_last) begin
        case (rcv_size)
          16'd1:   fifo_be = 4'b0001;
          16'd2:   fifo_be = 4'b0011;
          16'd3:   fifo_be = 4'b0111;
          default: fifo_be = 4'b1111;
        endcase
      end
    end
  end

  assign rcv_ovf = ovf_q;

endmodule

// File: tb/tb_rcv_seq.sv
// Bench for rcv_seq: directed cycle tables, reset abort and
// randomized traffic against a transaction-level model.
module tb_rcv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_vld = 1'b0, cmd_wr = 1'b0, cs_rise = 1'b0;
  logic        word_vld = 1'b0, fifo_full = 1'b0;
  logic [31:0] word_data = 32'd0;
  logic        rcv_last, rcv_done;
  logic [15:0] rcv_size;
  logic        rcv_wr_d, rcv_bc_d, rcv_clr;
  logic        rcv_nxt0, rcv_nxt1, rcv_nxtk;
  logic        fifo_wr, rcv_busy, rcv_cmplt, rcv_ovf;
  logic [31:0] fifo_wdata;
  logic [3:0]  fifo_be;

  logic [15:0] cnt;
  logic [15:0] ld_size = 16'd0;
  int          n_chk = 0;
  int          n_pass = 0;

  always #5 clk = ~clk;

  rcv_seq dut (
    .clk(clk), .rst_n(rst_n), .cmd_vld(cmd_vld), .cmd_wr(cmd_wr),
    .cs_rise(cs_rise), .word_vld(word_vld), .word_data(word_data),
    .fifo_full(fifo_full), .rcv_last(rcv_last), .rcv_done(rcv_done),
    .rcv_size(rcv_size), .rcv_wr_d(rcv_wr_d), .rcv_bc_d(rcv_bc_d),
    .rcv_clr(rcv_clr), .rcv_nxt0(rcv_nxt0), .rcv_nxt1(rcv_nxt1),
    .rcv_nxtk(rcv_nxtk), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
    .fifo_be(fifo_be), .rcv_busy(rcv_busy), .rcv_cmplt(rcv_cmplt),
    .rcv_ovf(rcv_ovf)
  );

  // Size counter the sequencer talks to.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 16'd0;
    else if (rcv_clr) cnt <= 16'd0;
    else if (rcv_wr_d || rcv_bc_d) cnt <= ld_size;
    else if (rcv_nxt0 || rcv_nxt1 || rcv_nxtk)
      cnt <= cnt - ((cnt > 16'd4) ? 16'd4 : cnt);
  end
  assign rcv_size = cnt;
  assign rcv_done = (cnt == 16'd0);
  assign rcv_last = (cnt < 16'd5);

  // {wr_d,bc_d,clr}_{nxt0,nxt1,nxtk}_{fifo_wr}_{be}_{busy,cmplt,ovf}
  logic [13:0] act;
  assign act = {rcv_wr_d, rcv_bc_d, rcv_clr, rcv_nxt0, rcv_nxt1,
                rcv_nxtk, fifo_wr, fifo_be, rcv_busy, rcv_cmplt,
                rcv_ovf};

  typedef struct {
    logic        cv, cw, cs, wv, ff;
    logic [15:0] sz;
    logic [13:0] exp;
  } vec_t;
  vec_t tbl[$];

  task automatic add(input logic cv, cw, cs, wv, ff,
                     input logic [15:0] sz, input logic [13:0] exp);
    vec_t v;
    v.cv = cv; v.cw = cw; v.cs = cs; v.wv = wv; v.ff = ff;
    v.sz = sz; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic cmp(input string nm, input logic [13:0] a,
                     input logic [13:0] e, input logic [31:0] wd,
                     input logic [31:0] ewd);
    n_chk++;
    if (a === e) n_pass++;
    else $display("FAIL %s: outputs got %b want %b", nm, a, e);
    n_chk++;
    if (wd === ewd) n_pass++;
    else $display("FAIL %s wdata: got %h want %h", nm, wd, ewd);
  endtask

  task automatic drive(input logic cv, cw, cs, wv, ff,
                       input logic [15:0] sz);
    @(negedge clk);
    cmd_vld = cv; cmd_wr = cw; cs_rise = cs;
    word_vld = wv; fifo_full = ff; ld_size = sz;
    word_data = $urandom;
    #1;
  endtask

  task automatic step(input string nm, input logic cv, cw, cs, wv, ff,
                      input logic [15:0] sz, input logic [13:0] exp);
    drive(cv, cw, cs, wv, ff, sz);
    cmp(nm, act, exp, fifo_wdata, exp[7] ? word_data : 32'd0);
  endtask

  // Transaction-level reference: phase of the command, bytes left.
  int          ph = 0;
  bit          m_wr, m_first, m_ovf;
  int          m_rem;
  logic [13:0] e;

  task automatic model_cycle();
    bit wr_d, bc_d, clr, n0, n1, nk, fw, busy, cpl;
    logic [3:0] be;
    int nph;
    bit ab;
    wr_d = 0; bc_d = 0; clr = 0; n0 = 0; n1 = 0; nk = 0;
    fw = 0; cpl = 0; be = 4'b0;
    busy = (ph != 0);
    ab = cs_rise && busy;
    nph = ph;
    e = 14'd0;
    if (ab) begin
      clr = 1; nph = 0;
    end else if (ph == 0) begin
      if (cmd_vld) begin
        m_wr = cmd_wr; m_first = 1; nph = 1;
      end
    end else if (ph == 1) begin
      wr_d = m_wr; bc_d = !m_wr;
      m_rem = ld_size; nph = 2;
    end else if (ph == 2) begin
      nph = (m_rem == 0) ? 4 : 3;
    end else if (ph == 3) begin
      if (word_vld) begin
        if (fifo_full) nk = 1;
        else begin
          fw = 1; n0 = m_first; n1 = !m_first;
          be = (m_rem >= 4) ? 4'b1111 : 4'((1 << m_rem) - 1);
        end
        m_first = 0;
        if (m_rem <= 4) begin
          m_rem = 0; nph = 4;
        end else m_rem -= 4;
      end
    end else begin
      clr = 1; cpl = 1; nph = 0;
    end
    e = {wr_d, bc_d, clr, n0, n1, nk, fw, be, busy, cpl, m_ovf};
    if (ph == 0 && cmd_vld) m_ovf = 0;
    if (ph == 3 && !ab && word_vld && fifo_full) m_ovf = 1;
    ph = nph;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    #1;
    cmp("reset", act, 14'd0, fifo_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // write 10 bytes, three words
    add(1,1,0,0,0,10, 14'b000_000_0_0000_000);
    add(0,0,0,0,0,10, 14'b100_000_0_0000_100);
    add(0,0,0,0,0,10, 14'b000_000_0_0000_100);
    add(0,0,0,1,0,10, 14'b000_100_1_1111_100);
    add(0,0,0,0,0,10, 14'b000_000_0_0000_100);
    add(0,0,0,1,0,10, 14'b000_010_1_1111_100);
    add(0,0,0,1,0,10, 14'b000_010_1_0011_100);
    add(0,0,0,0,0,10, 14'b001_000_0_0000_110);
    add(0,0,0,0,0,10, 14'b000_000_0_0000_000);
    // burst of size 0, then a stray word in idle
    add(1,0,0,0,0,0, 14'b000_000_0_0000_000);
    add(0,0,0,0,0,0, 14'b010_000_0_0000_100);
    add(0,0,0,0,0,0, 14'b000_000_0_0000_100);
    add(0,0,0,0,0,0, 14'b001_000_0_0000_110);
    add(0,0,0,1,0,0, 14'b000_000_0_0000_000);
    // write 8 with overflow on word 2
    add(1,1,0,0,0,8, 14'b000_000_0_0000_000);
    add(0,0,0,0,0,8, 14'b100_000_0_0000_100);
    add(0,0,0,0,0,8, 14'b000_000_0_0000_100);
    add(0,0,0,1,0,8, 14'b000_100_1_1111_100);
    add(0,0,0,1,1,8, 14'b000_001_0_0000_100);
    add(0,0,0,0,0,8, 14'b001_000_0_0000_111);
    add(0,0,0,0,0,8, 14'b000_000_0_0000_001);
    // next command clears ovf; write 16 aborted on word 2
    add(1,1,0,0,0,16, 14'b000_000_0_0000_001);
    add(0,0,0,0,0,16, 14'b100_000_0_0000_100);
    add(0,0,0,0,0,16, 14'b000_000_0_0000_100);
    add(0,0,0,1,0,16, 14'b000_100_1_1111_100);
    add(0,0,1,1,0,16, 14'b001_000_0_0000_100);
    add(0,0,0,0,0,16, 14'b000_000_0_0000_000);
    // cmd_vld during RECV is ignored
    add(1,1,0,0,0,12, 14'b000_000_0_0000_000);
    add(0,0,0,0,0,12, 14'b100_000_0_0000_100);
    add(0,0,0,0,0,12, 14'b000_000_0_0000_100);
    add(1,0,0,1,0,12, 14'b000_100_1_1111_100);
    add(0,0,0,1,0,12, 14'b000_010_1_1111_100);
    add(0,0,0,1,0,12, 14'b000_010_1_1111_100);
    add(0,0,0,0,0,12, 14'b001_000_0_0000_110);
    add(0,0,0,0,0,12, 14'b000_000_0_0000_000);

    for (int i = 0; i < tbl.size(); i++)
      step($sformatf("tbl[%0d]", i), tbl[i].cv, tbl[i].cw,
           tbl[i].cs, tbl[i].wv, tbl[i].ff, tbl[i].sz, tbl[i].exp);

    // reset in RECV after one of four words
    step("r_cmd",  1,1,0,0,0,16, 14'b000_000_0_0000_000);
    step("r_load", 0,0,0,0,0,16, 14'b100_000_0_0000_100);
    step("r_chk",  0,0,0,0,0,16, 14'b000_000_0_0000_100);
    step("r_w1",   0,0,0,1,0,16, 14'b000_100_1_1111_100);
    @(negedge clk);
    word_vld = 1'b1;
    word_data = $urandom;
    rst_n = 1'b0;
    #1;
    cmp("r_in_reset", act, 14'd0, fifo_wdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      step($sformatf("r_after[%0d]", i), 0,0,0,1,0,16, 14'd0);

    // randomized traffic against the model
    ph = 0; m_ovf = 0; m_first = 1; m_wr = 0; m_rem = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      cmd_vld   = ($urandom_range(0, 4) == 0);
      cmd_wr    = $urandom_range(0, 1);
      cs_rise   = ($urandom_range(0, 29) == 0);
      word_vld  = $urandom_range(0, 1);
      fifo_full = ($urandom_range(0, 3) == 0);
      word_data = $urandom;
      if (ph == 0) ld_size = 16'($urandom_range(0, 24));
      #1;
      model_cycle();
      cmp($sformatf("rand[%0d]", c), act, e, fifo_wdata,
          e[7] ? word_data : 32'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
